// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS core: opcodes, controller states,
// datapath select encodings and the packed control word.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } t_opcode;

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_J_EX     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_HALT     = 4'd13,
    S_TRAP     = 4'd14
  } t_mc_state;

  typedef logic [1:0] t_alu_src_b;
  typedef logic [1:0] t_alu_op;
  typedef logic [1:0] t_pc_source;

  localparam t_alu_src_b SRC_B_RT      = 2'b00;
  localparam t_alu_src_b SRC_B_FOUR    = 2'b01;
  localparam t_alu_src_b SRC_B_IMM     = 2'b10;
  localparam t_alu_src_b SRC_B_IMM_SH2 = 2'b11;

  localparam t_alu_op ALU_OP_ADD   = 2'b00;
  localparam t_alu_op ALU_OP_SUB   = 2'b01;
  localparam t_alu_op ALU_OP_FUNCT = 2'b10;

  localparam t_pc_source PC_SRC_ALU    = 2'b00;
  localparam t_pc_source PC_SRC_ALUOUT = 2'b01;
  localparam t_pc_source PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    t_alu_src_b alu_src_b;
    t_alu_op    alu_op;
    t_pc_source pc_source;
    logic       retire;
    logic       halted;
  } t_mc_ctrl;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle: decode feedback in, mux selects and enables out.
interface mips_mc_ctrl_if;
  import mips_pkg::*;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  t_alu_src_b alu_src_b;
  t_alu_op    alu_op;
  t_pc_source pc_source;

  // Memory handshake: a request (mem_read or mem_write) stays asserted with a
  // stable address select until the cycle mem_ready is high; that cycle
  // completes the transfer. mem_ready outside a request carries no meaning.
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source
  );

endinterface

// File: rtl/mips_mc_ctrl_outdec.sv
// Combinational control-word decoder: every datapath select and enable as a
// function of the current state, gated only by mem_ready and zero.
module mips_mc_outdec
  import mips_pkg::*;
(
  input  t_mc_state  state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output t_mc_ctrl   ctrl,
  output logic       op_legal
);

  assign op_legal = op_is_legal(opcode);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC+4 commit together, only in the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_source = PC_SRC_ALUOUT;
        ctrl.pc_en     = zero;
        ctrl.retire    = 1'b1;
      end
      S_J_EX: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_en     = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: state register, next-state sequencing,
// sticky illegal-opcode flag and retired-instruction counter.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_ctrl_if.master       bus,
  input  logic                 halt_req,
  output logic [3:0]           state,
  output logic                 retire,
  output logic                 illegal,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  t_mc_state              state_q;
  t_mc_state              state_nxt;
  t_mc_state              boundary_nxt;
  t_mc_ctrl               ctrl;
  logic                   op_legal;
  logic                   illegal_q;
  logic [INSTRET_W-1:0]   instret_q;

  mips_mc_outdec u_outdec (
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .zero      (bus.zero),
    .ctrl      (ctrl),
    .op_legal  (op_legal)
  );

  assign boundary_nxt = halt_req ? S_HALT : S_FETCH;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_START:  state_nxt = halt_req ? S_HALT : S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BEQ_EX;
          OP_J:         state_nxt = S_J_EX;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_nxt = S_MEM_WB;
      S_R_EXEC:   state_nxt = S_R_WB;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      // Every retiring state leaves through the instruction boundary; MEM_WR
      // retires only once its write handshake completes.
      S_MEM_WB, S_MEM_WR, S_R_WB, S_BEQ_EX, S_J_EX, S_ADDI_WB:
        if (ctrl.retire) state_nxt = boundary_nxt;
      S_HALT:     if (!halt_req) state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_START;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_DECODE && !op_legal) illegal_q <= 1'b1;
      if (ctrl.retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign bus.pc_en      = ctrl.pc_en;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_source  = ctrl.pc_source;

  assign state   = state_q;
  assign retire  = ctrl.retire;
  assign halted  = ctrl.halted;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed scenarios plus randomized instruction
// streams checked every cycle against a phase-queue model of the controller.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  localparam int IW = 8;
  localparam int B_PE = 17, B_IOD = 16, B_MRD = 15, B_MWR = 14, B_IRW = 13;
  localparam int B_M2R = 12, B_RW = 10, B_RET = 2, B_ILL = 1, B_HLT = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt_req;
  logic [3:0]    state;
  logic          retire, illegal, halted;
  logic [IW-1:0] instret;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.INSTRET_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .halt_req (halt_req),
    .state    (state),
    .retire   (retire),
    .illegal  (illegal),
    .halted   (halted),
    .instret  (instret)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state and scoreboard
  t_mc_state   m_cur;
  t_mc_state   m_q[$];
  logic        m_ill;
  int unsigned m_ret;
  logic [21:0] exp_q[$];
  logic [21:0] obs;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected control word straight from the per-state output table.
  function automatic logic [21:0] exp_word(input t_mc_state s, input logic mr,
                                           input logic z, input logic ill);
    logic pe, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ret, hl;
    logic [1:0] sb, ao, ps;
    {pe, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ret, hl} = '0;
    {sb, ao, ps} = '0;
    case (s)
      S_FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
      S_DECODE:   sb = 2'b11;
      S_MEM_ADDR: begin asa = 1; sb = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iod = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; ret = 1; end
      S_MEM_WR:   begin mwr = 1; iod = 1; ret = mr; end
      S_R_EXEC:   begin asa = 1; ao = 2'b10; end
      S_R_WB:     begin rw = 1; rdst = 1; ret = 1; end
      S_BEQ_EX:   begin asa = 1; ao = 2'b01; ps = 2'b01; pe = z; ret = 1; end
      S_J_EX:     begin ps = 2'b10; pe = 1; ret = 1; end
      S_ADDI_EX:  begin asa = 1; sb = 2'b10; end
      S_ADDI_WB:  begin rw = 1; ret = 1; end
      S_HALT:     hl = 1;
      default:    ;
    endcase
    return {4'(s), pe, iod, mrd, mwr, irw, m2r, rdst, rw, asa, sb, ao, ps, ret, ill, hl};
  endfunction

  function automatic logic [21:0] dut_word();
    return {state, bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_source, retire, illegal, halted};
  endfunction

  task automatic model_reset();
    m_cur = S_START;
    m_q.delete();
    m_ill = 1'b0;
    m_ret = 0;
  endtask

  // Decode loads the remaining phases of the instruction; the phase queue
  // drains one per cycle except while a memory phase waits for mem_ready.
  task automatic model_step(input logic [5:0] op, input logic mr, input logic hq,
                            input logic ret);
    if (ret) m_ret = (m_ret + 1) % (1 << IW);
    case (m_cur)
      S_START: m_cur = hq ? S_HALT : S_FETCH;
      S_HALT:  if (!hq) m_cur = S_FETCH;
      S_TRAP:  ;
      S_FETCH: if (mr) m_cur = S_DECODE;
      S_DECODE: begin
        m_q.delete();
        case (op)
          6'b000000: begin m_q.push_back(S_R_EXEC); m_q.push_back(S_R_WB); end
          6'b100011: begin m_q.push_back(S_MEM_ADDR); m_q.push_back(S_MEM_RD);
                           m_q.push_back(S_MEM_WB); end
          6'b101011: begin m_q.push_back(S_MEM_ADDR); m_q.push_back(S_MEM_WR); end
          6'b000100: m_q.push_back(S_BEQ_EX);
          6'b000010: m_q.push_back(S_J_EX);
          6'b001000: begin m_q.push_back(S_ADDI_EX); m_q.push_back(S_ADDI_WB); end
          default:   m_q.push_back(S_TRAP);
        endcase
        m_cur = m_q.pop_front();
        if (m_cur == S_TRAP) m_ill = 1'b1;
      end
      default: begin
        if ((m_cur == S_MEM_RD || m_cur == S_MEM_WR) && !mr) ;
        else if (m_q.size() > 0) m_cur = m_q.pop_front();
        else m_cur = hq ? S_HALT : S_FETCH;
      end
    endcase
  endtask

  // One clock: entered at a falling edge with inputs already driven.
  task automatic cycle();
    logic [21:0] e;
    #1;
    e = exp_word(m_cur, bus.mem_ready, bus.zero, m_ill);
    exp_q.push_back(e);
    obs = dut_word();
    chk("ctrl_word", 64'(obs), 64'(exp_q.pop_front()));
    chk("instret", 64'(instret), 64'(m_ret));
    @(posedge clk);
    if (rst) model_step(bus.opcode, bus.mem_ready, halt_req, e[B_RET]);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cycle();
    chk("rst_outputs", 64'(obs), 64'({4'(S_START), 18'b0}));
    cycle();
    rst = 1'b1;
  endtask

  task automatic reset_to_fetch();
    halt_req = 1'b0;
    do_reset();
    cycle();
  endtask

  task automatic run_instr(input logic [5:0] op, input int waits, input logic halt_at_exec,
                           output int cyc, output int rd_cyc, output int wb_cnt,
                           output logic pe_at_ret);
    int w;
    w = 0; cyc = 0; rd_cyc = 0; wb_cnt = 0; pe_at_ret = 1'b0;
    bus.opcode = op;
    for (int n = 0; n < 40; n++) begin
      bus.mem_ready = 1'b1;
      if ((m_cur == S_MEM_RD || m_cur == S_MEM_WR) && w < waits) begin
        bus.mem_ready = 1'b0;
        w++;
      end
      if (halt_at_exec && m_cur == S_R_EXEC) halt_req = 1'b1;
      cycle();
      cyc++;
      if (obs[B_MRD] && obs[B_IOD]) rd_cyc++;
      if (obs[B_RW] && obs[B_M2R]) wb_cnt++;
      if (obs[B_RET]) begin
        pe_at_ret = obs[B_PE];
        break;
      end
    end
  endtask

  logic [5:0] legal_ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    int cyc, rd_cyc, wb_cnt, ret_cnt, bad, trap_cnt;
    logic pe;
    t_mc_state add_seq[5];
    add_seq = '{S_START, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB};
    rst = 1'b1;
    halt_req = 1'b0;
    bus.opcode = 6'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    do_reset();

    // ADD with zero-wait memory: START, FETCH, DECODE, R_EXEC, R_WB
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    ret_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("add_state%0d", i + 1), 64'(obs[21:18]), 64'(add_seq[i]));
      if (obs[B_RET]) ret_cnt += (i == 4) ? 1 : 10;
    end
    chk("add_retire_once_at_5", 64'(ret_cnt), 64'd1);
    chk("add_instret", 64'(instret), 64'd1);

    // LW with three wait cycles in MEM_RD
    run_instr(6'b100011, 3, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("lw_cycles", 64'(cyc), 64'd8);
    chk("lw_read_hold", 64'(rd_cyc), 64'd4);
    chk("lw_wb_once", 64'(wb_cnt), 64'd1);

    // BEQ taken then not taken
    bus.zero = 1'b1;
    run_instr(6'b000100, 0, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("beq_taken_cycles", 64'(cyc), 64'd3);
    chk("beq_taken_pc_en", 64'(pe), 64'd1);
    bus.zero = 1'b0;
    run_instr(6'b000100, 0, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("beq_not_taken_cycles", 64'(cyc), 64'd3);
    chk("beq_not_taken_pc_en", 64'(pe), 64'd0);

    // SW and ADDI minimum latency
    run_instr(6'b101011, 0, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("sw_cycles", 64'(cyc), 64'd4);
    run_instr(6'b001000, 0, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("addi_cycles", 64'(cyc), 64'd4);

    // halt requested mid-instruction takes effect at the boundary
    run_instr(6'b000000, 0, 1'b1, cyc, rd_cyc, wb_cnt, pe);
    chk("halt_instr_completes", 64'(cyc), 64'd4);
    cycle();
    chk("halt_state", 64'(obs[21:18]), 64'(S_HALT));
    chk("halt_flag", 64'(obs[B_HLT]), 64'd1);
    cycle();
    halt_req = 1'b0;
    cycle();
    cycle();
    chk("halt_release_fetch", 64'(obs[21:18]), 64'(S_FETCH));

    // undefined opcode traps until reset
    reset_to_fetch();
    bus.opcode = 6'b111111;
    cycle();
    cycle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cycle();
      if (obs[21:18] != 4'(S_TRAP) || !obs[B_ILL] ||
          obs[B_PE] || obs[B_MRD] || obs[B_MWR] || obs[B_IRW] || obs[B_RW]) bad++;
    end
    chk("trap_quiet_sticky", 64'(bad), 64'd0);
    do_reset();
    chk("trap_cleared", 64'(obs[B_ILL]), 64'd0);

    // reset while SW waits on memory
    bus.mem_ready = 1'b1;
    cycle();
    bus.opcode = 6'b101011;
    for (int i = 0; i < 10 && m_cur != S_MEM_WR; i++) cycle();
    bus.mem_ready = 1'b0;
    cycle();
    cycle();
    chk("sw_write_held", 64'(obs[B_MWR]), 64'd1);
    do_reset();

    // instret wraps at 2^IW
    bus.mem_ready = 1'b1;
    cycle();
    for (int i = 0; i < (1 << IW) - 1; i++) run_instr(6'b000010, 0, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("instret_max", 64'(instret), 64'((1 << IW) - 1));
    run_instr(6'b000010, 0, 1'b0, cyc, rd_cyc, wb_cnt, pe);
    chk("instret_wrap", 64'(instret), 64'd0);

    // randomized instruction stream
    trap_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.zero = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      if (m_cur == S_FETCH)
        bus.opcode = ($urandom_range(0, 40) == 0) ? 6'($urandom_range(0, 63))
                                                  : legal_ops[$urandom_range(0, 5)];
      trap_cnt = (m_cur == S_TRAP) ? trap_cnt + 1 : 0;
      if (trap_cnt > 4 || $urandom_range(0, 399) == 0) begin
        do_reset();
        trap_cnt = 0;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
